// File: rtl/drm_stream_pkg.sv
// ---------------------------------------------------------------------------
// drm_stream_pkg
// Shared definitions for the DRM controller AXI4-Stream elastic buffer.
//   DEFAULT_DATA_WIDTH : stream width used by the DRM controller (32 bits)
//   DEFAULT_DEPTH      : default buffer depth in entries (16)
//   STATS_W            : width of the optional frame counter
//   drm_axis_word_t    : one stored stream beat, {last, data}
//   addr_w()           : pointer width for a given depth
// ---------------------------------------------------------------------------
package drm_stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 16;
  localparam int STATS_W            = 32;

  typedef struct packed {
    logic                          last;
    logic [DEFAULT_DATA_WIDTH-1:0] data;
  } drm_axis_word_t;

  // Pointer width; the depth is a power of two, so pointers wrap for free.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/drm_stream_fifo_mem.sv
// ---------------------------------------------------------------------------
// drm_stream_fifo_mem
// Simple dual-port storage array for the stream buffer: one synchronous
// write port and one asynchronous read port, so it maps onto distributed
// RAM. No reset: contents are only meaningful behind the top-level count.
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from raddr)
// ---------------------------------------------------------------------------
module drm_stream_fifo_mem #(
  parameter int WIDTH  = 33,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/drm_stream_fifo.sv
// ---------------------------------------------------------------------------
// drm_stream_fifo
// AXI4-Stream elastic buffer placed on a DRM controller stream. Single clock,
// first-word-fall-through, registered tready/tvalid, no s->m bypass and no
// same-cycle pass-through when full. Order of {tlast, tdata} is preserved.
// Ports:
//   ap_clk, ap_rst_n                  clock, asynchronous active-low reset
//   s_axis_tvalid/tready/tdata/tlast  upstream stream slave
//   m_axis_tvalid/tready/tdata/tlast  downstream stream master
//   level                             current occupancy, 0..C_DEPTH
// Optional (macro DRM_STREAM_FIFO_STATS_EN):
//   stats_clear     in   synchronous clear of the statistics
//   frame_count     out  popped words with tlast = 1, saturating
//   high_watermark  out  largest occupancy seen since reset/clear
// ---------------------------------------------------------------------------
module drm_stream_fifo
  import drm_stream_pkg::*;
#(
  parameter int C_DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int C_DEPTH      = DEFAULT_DEPTH
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                      s_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic [$clog2(C_DEPTH):0]  level
`ifdef DRM_STREAM_FIFO_STATS_EN
  ,
  input  logic                      stats_clear,
  output logic [STATS_W-1:0]        frame_count,
  output logic [$clog2(C_DEPTH):0]  high_watermark
`endif
);

  localparam int ADDR_W = addr_w(C_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(C_DEPTH);

  // Non power-of-two depths would break the free pointer wrap.
  generate
    if ((C_DEPTH < 2) || ((C_DEPTH & (C_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("drm_stream_fifo: C_DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  push;
  logic                  pop;
  logic [C_DATA_WIDTH:0] rd_word;

  assign push = s_axis_tvalid & s_axis_tready;
  assign pop  = m_axis_tvalid & m_axis_tready;

  always_comb begin
    cnt_next = cnt;
    if (push && !pop) begin
      cnt_next = cnt + 1'b1;
    end else if (pop && !push) begin
      cnt_next = cnt - 1'b1;
    end
  end

  // Flags are computed from the next count so they are registered yet exact;
  // this is why a pop while full only reopens tready on the following cycle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt           <= cnt_next;
      s_axis_tready <= (cnt_next < FULL_CNT);
      m_axis_tvalid <= (cnt_next != '0);
    end
  end

  drm_stream_fifo_mem #(
    .WIDTH  (C_DATA_WIDTH + 1),
    .DEPTH  (C_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (ap_clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({s_axis_tlast, s_axis_tdata}),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  assign m_axis_tlast = rd_word[C_DATA_WIDTH];
  assign m_axis_tdata = rd_word[C_DATA_WIDTH-1:0];
  assign level        = cnt;

`ifdef DRM_STREAM_FIFO_STATS_EN
  logic [STATS_W-1:0] frame_cnt;
  logic [CNT_W-1:0]   hwm;

  // Clear has priority over any increment in the same cycle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      frame_cnt <= '0;
      hwm       <= '0;
    end else if (stats_clear) begin
      frame_cnt <= '0;
      hwm       <= '0;
    end else begin
      if (pop && m_axis_tlast && (frame_cnt != '1)) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (cnt > hwm) begin
        hwm <= cnt;
      end
    end
  end

  assign frame_count    = frame_cnt;
  assign high_watermark = hwm;
`endif

endmodule

// File: tb/tb_drm_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_drm_stream_fifo
// Self-checking bench for drm_stream_fifo. Accepted words are pushed into an
// expected queue by the driver; a monitor pops and compares on every output
// handshake and checks that a stalled head stays put.
// Optional statistics are exercised when DRM_STREAM_FIFO_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_drm_stream_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic [LW-1:0] level;
`ifdef DRM_STREAM_FIFO_STATS_EN
  logic          stats_clear = 1'b0;
  logic [31:0]   frame_count;
  logic [LW-1:0] high_watermark;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW:0] expQueue [$];
  logic [DW:0] expWord;
  logic [DW:0] prevWord;
  logic        prevStall = 1'b0;
  logic        streamMode = 1'b0;
  logic        producerDone = 1'b0;

  drm_stream_fifo #(
    .C_DATA_WIDTH (DW),
    .C_DEPTH      (DEPTH)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .level         (level)
`ifdef DRM_STREAM_FIFO_STATS_EN
    ,
    .stats_clear    (stats_clear),
    .frame_count    (frame_count),
    .high_watermark (high_watermark)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  always #5 ap_clk = ~ap_clk;

  // Single comparison point: counts every check and reports any miss.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s (bound expired or unexpected event)", name);
  endtask

  // Drives one word from just after a rising edge and holds it until the
  // buffer accepts it; the accepted word is queued as an expected output.
  task automatic applyStimulus(input logic [DW-1:0] data, input logic last);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    for (int k = 0; k < 200; k++) begin
      @(negedge ap_clk);
      if (s_axis_tready) begin
        expQueue.push_back({last, data});
        @(posedge ap_clk);
        #1;
        s_axis_tvalid = 1'b0;
        return;
      end
      @(posedge ap_clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    failNow("push_timeout");
  endtask

  // Waits (bounded) for the buffer and the expected queue to empty.
  task automatic waitDrain(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge ap_clk);
      if ((expQueue.size() == 0) && (level == '0)) begin
        checkOutput("drain_tvalid_low", m_axis_tvalid, 1'b0);
        @(posedge ap_clk);
        #1;
        return;
      end
    end
    failNow("drain_timeout");
    @(posedge ap_clk);
    #1;
  endtask

  // Monitor: compares every output handshake against the scoreboard and
  // checks that a stalled head word keeps tvalid and its data stable.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_tvalid_held", m_axis_tvalid, 1'b1);
        checkOutput("stall_word_held", {m_axis_tlast, m_axis_tdata}, prevWord);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (expQueue.size() == 0) begin
          failNow("unexpected_output_word");
        end else begin
          expWord = expQueue.pop_front();
          checkOutput("scoreboard_word", {m_axis_tlast, m_axis_tdata}, expWord);
        end
      end
      if (streamMode) begin
        checkOutput("stream_level_le1", (level <= 1), 1'b1);
      end
      prevStall = m_axis_tvalid && !m_axis_tready;
      prevWord  = {m_axis_tlast, m_axis_tdata};
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks + 1, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held for five cycles.
    ap_rst_n = 1'b0;
    repeat (5) @(posedge ap_clk);
    #1;
    checkOutput("reset_tready", s_axis_tready, 1'b0);
    checkOutput("reset_tvalid", m_axis_tvalid, 1'b0);
    checkOutput("reset_level", level, '0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    checkOutput("tready_before_first_edge", s_axis_tready, 1'b0);
    @(posedge ap_clk);
    #1;
    checkOutput("tready_after_first_edge", s_axis_tready, 1'b1);

    // Single word: no combinational bypass, visible right after its edge.
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hA5A5_A5A5;
    s_axis_tlast  = 1'b1;
    @(negedge ap_clk);
    checkOutput("single_no_bypass", m_axis_tvalid, 1'b0);
    checkOutput("single_tready", s_axis_tready, 1'b1);
    expQueue.push_back({1'b1, 32'hA5A5_A5A5});
    @(posedge ap_clk);
    #1;
    s_axis_tvalid = 1'b0;
    checkOutput("single_tvalid", m_axis_tvalid, 1'b1);
    checkOutput("single_tdata", m_axis_tdata, 32'hA5A5_A5A5);
    checkOutput("single_tlast", m_axis_tlast, 1'b1);
    checkOutput("single_level", level, 1);
    m_axis_tready = 1'b1;
    @(posedge ap_clk);
    #1;
    m_axis_tready = 1'b0;
    checkOutput("single_level_after_pop", level, 0);
    checkOutput("single_tvalid_after_pop", m_axis_tvalid, 1'b0);

    // Fill to full with the output stalled.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(32'(i), (i == DEPTH - 1));
    end
    checkOutput("full_tready", s_axis_tready, 1'b0);
    checkOutput("full_level", level, DEPTH);
    checkOutput("full_head_data", m_axis_tdata, 32'h0);
    // A 17th word is offered but must not be taken.
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hDEAD_0011;
    s_axis_tlast  = 1'b0;
    repeat (3) begin
      @(posedge ap_clk);
      #1;
      checkOutput("full_rejects_level", level, DEPTH);
      checkOutput("full_rejects_tready", s_axis_tready, 1'b0);
    end
    // Pop one while the 17th is still offered: no same-cycle pass-through.
    m_axis_tready = 1'b1;
    @(posedge ap_clk);
    #1;
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b0;
    checkOutput("pop_from_full_level", level, DEPTH - 1);
    checkOutput("pop_from_full_tready", s_axis_tready, 1'b1);
    checkOutput("pop_from_full_head", m_axis_tdata, 32'h1);
    m_axis_tready = 1'b1;
    waitDrain(100);

    // Streaming: both sides always ready for 1000 words.
    streamMode = 1'b1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(32'h1000_0000 + 32'(i * 7), ($urandom_range(0, 3) == 0));
    end
    streamMode = 1'b0;
    waitDrain(50);

    // Random valid/ready patterns, 10k words.
    producerDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge ap_clk);
            #1;
          end
          applyStimulus(32'h5A00_0000 ^ 32'(i * 32'h0001_0003), ($urandom_range(0, 4) == 0));
        end
        producerDone = 1'b1;
      end
      begin
        while (!producerDone) begin
          @(posedge ap_clk);
          #1;
          m_axis_tready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    m_axis_tready = 1'b1;
    waitDrain(100);

`ifdef DRM_STREAM_FIFO_STATS_EN
    // Statistics: 3 frames of 4 words, 6 buffered at peak.
    stats_clear = 1'b1;
    @(posedge ap_clk);
    #1;
    stats_clear = 1'b0;
    @(posedge ap_clk);
    #1;
    checkOutput("stats_cleared_frames", frame_count, 0);
    checkOutput("stats_cleared_hwm", high_watermark, 0);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(32'hF000_0000 + 32'(i), ((i % 4) == 3));
    end
    @(posedge ap_clk);
    #1;
    checkOutput("stats_peak_level", level, 6);
    checkOutput("stats_peak_hwm", high_watermark, 6);
    m_axis_tready = 1'b1;
    waitDrain(50);
    for (int i = 6; i < 12; i++) begin
      applyStimulus(32'hF000_0000 + 32'(i), ((i % 4) == 3));
    end
    waitDrain(50);
    checkOutput("stats_frame_count", frame_count, 3);
    checkOutput("stats_hwm_final", high_watermark, 6);
    stats_clear = 1'b1;
    @(posedge ap_clk);
    #1;
    stats_clear = 1'b0;
    checkOutput("stats_clear_frames", frame_count, 0);
    checkOutput("stats_clear_hwm", high_watermark, 0);
`endif

    checkOutput("final_queue_empty", expQueue.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
